data_memory_be: RTL and testbench

Parametrised, byte-addressable successor to the CPU's word data memory, serving the MIPS single-cycle datapath for lw/lh/lhu/lb/lbu/sw/sh/sb. Adds per-byte write enables, sign/zero-extended sub-word loads, misalignment detection, and a multi-cycle clear sweep with a busy flag, because a single-cycle clear does not scale with depth. Sits between the ALU address output and the writeback mux.

---
 rtl/data_memory_be_pkg.sv | 44 ++++
 rtl/data_memory_be_load_extend.sv | 28 ++
 rtl/data_memory_be.sv | 113 +++++++++++
 tb/tb_data_memory_be.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_be_pkg.sv
// Shared encodings and helpers for the byte-enable data memory.
// Size codes, FSM states and lane byte-enable decode.
package data_memory_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic bad;
        bad = 1'b1;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/data_memory_be_load_extend.sv
// Picks the addressed byte/half/word out of a memory word and
// sign- or zero-extends it to 32 bits.
module load_extend
    import data_memory_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [1:0]  i_size,
    input  logic        i_sgn,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_word[{i_lane, 3'b000} +: 8];
    assign w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_data = i_word;
        case (i_size)
            SZ_BYTE: o_data = {{24{i_sgn & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{i_sgn & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressable data memory with lane enables, extended loads,
// misalignment detection and a multi-cycle clear sweep.
module data_memory_be
    import data_memory_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int AW         = DEPTH_LOG2 + 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          sel,
    input  logic          str,
    input  logic          ld,
    input  logic [1:0]    size,
    input  logic          sgn,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   data_in,
    output logic [31:0]   data_out,
    output logic          busy,
    output logic          misalign
);

    localparam int NWORDS = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST = '1;

    logic [31:0]           r_mem [NWORDS];
    state_t                r_state;
    state_t                w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_cnt;
    logic [DEPTH_LOG2-1:0] w_cnt_nxt;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic [1:0]            w_lane;
    logic [3:0]            w_be;
    logic [31:0]           w_wdata;
    logic                  w_we;
    logic                  w_ld_ok;
    logic [31:0]           w_ext;

    assign w_idx    = addr[AW-1:2];
    assign w_lane   = addr[1:0];
    assign busy     = (r_state == CLEAR);
    assign misalign = sel & (ld | str) & is_misaligned(size, w_lane);
    assign w_we     = sel & str & ~busy & ~misalign;
    assign w_ld_ok  = sel & ld & ~busy & ~misalign;
    assign w_be     = byte_en(size, w_lane);

    // Replicate sub-word data so every lane sees its own slice.
    always_comb begin
        w_wdata = data_in;
        case (size)
            SZ_BYTE: w_wdata = {4{data_in[7:0]}};
            SZ_HALF: w_wdata = {2{data_in[15:0]}};
            default: w_wdata = data_in;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                w_state_nxt = IDLE;
            end
            CLEAR: begin
                if (r_cnt == LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Stores are blocked while busy, so the sweep owns the array then.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    load_extend u_ext (
        .i_word (r_mem[w_idx]),
        .i_lane (w_lane),
        .i_size (size),
        .i_sgn  (sgn),
        .o_data (w_ext)
    );

    assign data_out = sel ? (w_ld_ok ? w_ext : 32'h0) : 32'hz;

endmodule

// File: tb/tb_data_memory_be.sv
// Directed and randomized checks of data_memory_be against a
// byte-array reference model.
module tb_data_memory_be;

    localparam int DL = 5;
    localparam int AW = DL + 2;
    localparam int NW = 1 << DL;
    localparam int NB = 4 * NW;

    logic          clk = 1'b0;
    logic          clr;
    logic          sel;
    logic          str;
    logic          ld;
    logic [1:0]    size;
    logic          sgn;
    logic [AW-1:0] addr;
    logic [31:0]   din;
    tri1  [31:0]   dout;
    logic          busy;
    logic          mis;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] mdl [NB];

    data_memory_be #(.DEPTH_LOG2(DL)) dut (
        .clk      (clk),
        .clr      (clr),
        .sel      (sel),
        .str      (str),
        .ld       (ld),
        .size     (size),
        .sgn      (sgn),
        .addr     (addr),
        .data_in  (din),
        .data_out (dout),
        .busy     (busy),
        .misalign (mis)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_mis(input logic [1:0] sz, input int a);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return (a % 2) != 0;
            2'd2:    return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz,
                                           input bit sg,
                                           input int a);
        int n;
        longint v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(mdl[a + i]) << (8 * i);
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic m_store(input logic [1:0] sz, input int a,
                           input logic [31:0] d);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++)
            mdl[a + i] = 8'(d >> (8 * i));
    endtask

    task automatic drv(input bit s, input bit st, input bit l,
                       input logic [1:0] sz, input bit sg,
                       input int a, input logic [31:0] d);
        sel  = s;
        str  = st;
        ld   = l;
        size = sz;
        sgn  = sg;
        addr = AW'(a);
        din  = d;
        #1;
    endtask

    // upd: the bench knows the memory is idle, so the model takes the store.
    task automatic tick(input bit upd);
        if (upd && sel && str && !m_mis(size, int'(addr)))
            m_store(size, int'(addr), din);
        @(posedge clk);
        #1;
    endtask

    task automatic ld_chk(input string tag, input logic [1:0] sz,
                          input bit sg, input int a,
                          input logic [31:0] exp);
        drv(1, 0, 1, sz, sg, a, 32'h0);
        chk(tag, dout, exp);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick(0);
            n++;
        end
    endtask

    initial begin
        int n;
        logic [31:0] e;
        clr = 1'b0;
        drv(0, 0, 0, 2'd0, 0, 0, 32'h0);
        @(posedge clk);
        #1;

        clr = 1'b1;
        tick(0);
        clr = 1'b0;
        chk("rst_busy", 32'(busy), 32'd1);
        drv(1, 0, 1, 2'd2, 0, 0, 32'h0);
        chk("rst_dout", dout, 32'h0);
        wait_idle(n);
        chk("clr_len", n, NW);
        for (int i = 0; i < NB; i++) mdl[i] = 8'h0;
        for (int w = 0; w < NW; w++)
            ld_chk("clr_word", 2'd2, 0, 4 * w, 32'h0);

        drv(1, 1, 0, 2'd2, 0, 'h28, 32'hDEADBEEF);
        tick(1);
        drv(1, 1, 0, 2'd0, 0, 'h29, 32'h12345680);
        tick(1);
        ld_chk("lw_28", 2'd2, 0, 'h28, 32'hDEAD80EF);
        ld_chk("lb_29", 2'd0, 1, 'h29, 32'hFFFFFF80);
        ld_chk("lbu_29", 2'd0, 0, 'h29, 32'h00000080);

        drv(1, 1, 0, 2'd2, 0, 'h50, 32'h11223344);
        tick(1);
        drv(1, 1, 0, 2'd1, 0, 'h52, 32'hABCDCAFE);
        tick(1);
        ld_chk("lh_52", 2'd1, 1, 'h52, 32'hFFFFCAFE);
        ld_chk("lhu_52", 2'd1, 0, 'h52, 32'h0000CAFE);
        ld_chk("lw_50", 2'd2, 0, 'h50, 32'hCAFE3344);

        drv(1, 1, 0, 2'd2, 0, 'h29, 32'h55555555);
        chk("mis_sw", 32'(mis), 32'd1);
        tick(1);
        ld_chk("lw_28_kept", 2'd2, 0, 'h28, 32'hDEAD80EF);
        drv(1, 0, 1, 2'd1, 1, 'h53, 32'h0);
        chk("mis_lh", 32'(mis), 32'd1);
        chk("mis_lh_d", dout, 32'h0);
        drv(1, 0, 1, 2'd3, 0, 'h28, 32'h0);
        chk("mis_sz3", 32'(mis), 32'd1);
        drv(0, 0, 1, 2'd2, 0, 'h28, 32'h0);
        chk("sel0_z", dout, 32'hFFFFFFFF);
        drv(0, 1, 1, 2'd3, 0, 'h28, 32'h0);
        chk("sel0_mis", 32'(mis), 32'd0);

        drv(1, 1, 0, 2'd2, 0, 'h10, 32'h11111111);
        tick(1);
        drv(1, 1, 1, 2'd2, 0, 'h10, 32'h22222222);
        chk("rw_pre", dout, 32'h11111111);
        tick(1);
        chk("rw_post", dout, 32'h22222222);

        drv(0, 0, 0, 2'd0, 0, 0, 32'h0);
        clr = 1'b1;
        tick(0);
        clr = 1'b0;
        for (int i = 0; i < 20; i++) tick(0);
        drv(1, 1, 0, 2'd2, 0, 'h40, 32'h12345678);
        tick(0);
        drv(0, 0, 0, 2'd0, 0, 0, 32'h0);
        wait_idle(n);
        chk("sweep_len", n + 21, NW);
        for (int i = 0; i < NB; i++) mdl[i] = 8'h0;
        ld_chk("drop_40", 2'd2, 0, 'h40, 32'h0);
        ld_chk("swept_10", 2'd2, 0, 'h10, 32'h0);

        drv(0, 0, 0, 2'd0, 0, 0, 32'h0);
        clr = 1'b1;
        tick(0);
        clr = 1'b0;
        for (int i = 0; i < 10; i++) tick(0);
        clr = 1'b1;
        tick(0);
        clr = 1'b0;
        wait_idle(n);
        chk("restart_len", n, NW);

        for (int k = 0; k < 400; k++) begin
            bit s;
            bit st;
            bit l;
            bit sg;
            logic [1:0] sz;
            int a;
            s  = ($urandom_range(0, 9) != 0);
            st = $urandom_range(0, 1) == 1;
            l  = $urandom_range(0, 1) == 1;
            sg = $urandom_range(0, 1) == 1;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, NB - 1);
            drv(s, st, l, sz, sg, a, $urandom);
            chk("rnd_mis", 32'(mis),
                32'(s && (st || l) && m_mis(sz, a)));
            if (!s) e = 32'hFFFFFFFF;
            else if (l && !m_mis(sz, a)) e = m_load(sz, sg, a);
            else e = 32'h0;
            chk("rnd_dout", dout, e);
            chk("rnd_busy", 32'(busy), 32'd0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
